// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared constants and helpers for the instruction ROM fetch arbiter.
// Bus widths, enable levels, response port codes and the starvation default.
// Also provides the counter-width and alignment helpers used by the RTL.
package rom_fetch_arbiter_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_DATA_BUS = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [INST_DATA_BUS-1:0] ZERO_WORD = '0;

  // Owner codes carried on rsp_port.
  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  // Bits needed to hold 0..limit; at least one bit so a zero limit still elaborates.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  // Instruction words are 4-byte aligned.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/rom_fetch_arbiter_if.sv
// Bundle of requester, response and ROM signals around the fetch arbiter.
// Ports: if_* (IF fetch), dbg_* (debug read), rsp_* (registered response), rom_* (ROM port).
// slave = the arbiter's view; master = the surrounding pipeline/debug/ROM view.
interface rom_fetch_arbiter_if
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int DATA_W = INST_DATA_BUS
);

  // IF-stage fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic              if_stall;

  // Debug / loader requester
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;

  // Registered response, one cycle after the grant
  logic              rsp_valid;
  logic              rsp_port;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  // Combinational ROM read port
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  if_req, if_addr, dbg_req, dbg_addr, rom_data,
    output if_ack, if_stall, dbg_ack,
    output rsp_valid, rsp_port, rsp_data, rsp_err,
    output rom_ce, rom_addr
  );

  modport master (
    output if_req, if_addr, dbg_req, dbg_addr, rom_data,
    input  if_ack, if_stall, dbg_ack,
    input  rsp_valid, rsp_port, rsp_data, rsp_err,
    input  rom_ce, rom_addr
  );

endinterface

// File: rtl/rom_fetch_arbiter_starve_counter.sv
// Saturating count of consecutive IF wins while the debug port waits.
// Ports: clock/reset; inc (IF won over a pending debug), clr (debug granted or idle), sat (limit reached).
// Clear has priority over increment; the count parks at LIMIT and never wraps.
module rom_starve_counter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int W = cnt_width(LIMIT);
  localparam logic [W-1:0] MAX = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign sat = (cnt == MAX);

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares the combinational instruction ROM port between IF fetch (port 0) and debug reads (port 1).
// Ports: clock, reset (async active-low), bus (slave modport: requests, acks, response, ROM drive).
// One grant per cycle, response registered one cycle later; IF has priority unless debug is starved.
module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W       = INST_ADDR_BUS,
  parameter int DATA_W       = INST_DATA_BUS,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  rom_fetch_arbiter_if.slave  bus
);

  logic              sat;
  logic              grant_if;
  logic              grant_dbg;
  logic              grant;
  logic              gnt_port;
  logic [ADDR_W-1:0] gnt_addr;
  logic              aligned;
  logic              rom_go;

  logic              rsp_valid_q;
  logic              rsp_port_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  // Debug wins when it is alone or once IF has won STARVE_LIMIT times in a row against it.
  always_comb begin
    grant_dbg = bus.dbg_req & (~bus.if_req | sat);
    grant_if  = bus.if_req & ~grant_dbg;
    grant     = grant_if | grant_dbg;
    gnt_port  = grant_dbg ? PORT_DBG : PORT_IF;
    gnt_addr  = grant_dbg ? bus.dbg_addr : bus.if_addr;
    aligned   = is_aligned(gnt_addr[1:0]);
    rom_go    = grant & aligned;
  end

  // A misaligned grant is still acked (it gets an error response) but never reaches the ROM.
  assign bus.if_ack   = grant_if;
  assign bus.dbg_ack  = grant_dbg;
  assign bus.if_stall = bus.if_req & ~grant_if;
  assign bus.rom_ce   = rom_go ? ENABLE : DISABLE;
  assign bus.rom_addr = rom_go ? gnt_addr : '0;

  rom_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock (clock),
    .reset (reset),
    .inc   (grant_if & bus.dbg_req),
    .clr   (grant_dbg | ~bus.dbg_req),
    .sat   (sat)
  );

  // Data and owner hold between responses; the error flag only qualifies a live response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= PORT_IF;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= grant;
      if (grant) begin
        rsp_port_q <= gnt_port;
        rsp_err_q  <= ~aligned;
        rsp_data_q <= aligned ? bus.rom_data : DATA_W'(ZERO_WORD);
      end else begin
        rsp_err_q  <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_port  = rsp_port_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter: directed scenarios plus a randomized run
// against a behavioural reference model of the arbitration and response rules.
// Inputs change on the falling edge; outputs are sampled 1ns after an edge.
module tb_rom_fetch_arbiter;

  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rom_fetch_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rom_fetch_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ROM model: 256 words, word index from byte address bits [9:2].
  logic [31:0] mem [256];
  logic [7:0]  rom_idx;
  assign rom_idx      = bus.rom_addr[9:2];
  assign bus.rom_data = mem[rom_idx];

  int checks = 0;
  int errors = 0;

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dbg_req  = dr;
    bus.dbg_addr = da;
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clock);
    #1;
  endtask

  // Reset holds registers at zero while acks/ROM drive still follow the inputs.
  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 32'h10, 1'b0, 32'h0);
    #1;
    checks++;
    if (bus.if_ack !== 1'b1 || bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h10) begin
      errors++;
      $display("FAIL reset_comb: ack=%b ce=%b addr=%h want ack=1 ce=1 addr=10", bus.if_ack, bus.rom_ce, bus.rom_addr);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_port !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: valid=%b port=%b data=%h err=%b want all 0", bus.rsp_valid, bus.rsp_port, bus.rsp_data, bus.rsp_err);
    end
    @(negedge clock);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
  endtask

  // Single IF fetch, then an idle cycle that must hold the returned word.
  task automatic test_if_single();
    idle_cycle();
    @(negedge clock);
    drive(1'b1, 32'h10, 1'b0, 32'h0);
    #1;
    checks++;
    if (bus.if_ack !== 1'b1 || bus.dbg_ack !== 1'b0 || bus.if_stall !== 1'b0 ||
        bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h10) begin
      errors++;
      $display("FAIL if_single_grant: ack=%b dack=%b stall=%b ce=%b addr=%h want 1 0 0 1 10",
               bus.if_ack, bus.dbg_ack, bus.if_stall, bus.rom_ce, bus.rom_addr);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_port !== 1'b0 || bus.rsp_data !== mem[4] || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL if_single_rsp: valid=%b port=%b data=%h err=%b want 1 0 %h 0",
               bus.rsp_valid, bus.rsp_port, bus.rsp_data, bus.rsp_err, mem[4]);
    end
    @(negedge clock);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if (bus.rom_ce !== 1'b0 || bus.rom_addr !== 32'h0 || bus.if_ack !== 1'b0 || bus.dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_rom: ce=%b addr=%h acks=%b%b want 0 0 00", bus.rom_ce, bus.rom_addr, bus.if_ack, bus.dbg_ack);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== mem[4] || bus.rsp_port !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: valid=%b data=%h port=%b want 0 %h 0", bus.rsp_valid, bus.rsp_data, bus.rsp_port, mem[4]);
    end
  endtask

  // Both requesting continuously: debug wins every fifth cycle.
  task automatic test_starve();
    idle_cycle();
    for (int c = 0; c < 10; c++) begin
      logic exp_dbg;
      exp_dbg = ((c % (LIMIT + 1)) == LIMIT);
      @(negedge clock);
      drive(1'b1, 32'h20, 1'b1, 32'h44);
      #1;
      checks++;
      if (bus.dbg_ack !== exp_dbg || bus.if_ack !== !exp_dbg || bus.if_stall !== exp_dbg) begin
        errors++;
        $display("FAIL starve_c%0d: dack=%b ack=%b stall=%b want dack=%b ack=%b stall=%b",
                 c, bus.dbg_ack, bus.if_ack, bus.if_stall, exp_dbg, !exp_dbg, exp_dbg);
      end
      @(posedge clock);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_port !== exp_dbg ||
          bus.rsp_data !== (exp_dbg ? mem[17] : mem[8])) begin
        errors++;
        $display("FAIL starve_rsp_c%0d: valid=%b port=%b data=%h want 1 %b %h",
                 c, bus.rsp_valid, bus.rsp_port, bus.rsp_data, exp_dbg, exp_dbg ? mem[17] : mem[8]);
      end
    end
  endtask

  // Misaligned debug read: acked, kept off the ROM, answered with an error.
  task automatic test_dbg_misaligned();
    idle_cycle();
    @(negedge clock);
    drive(1'b0, 32'h0, 1'b1, 32'h6);
    #1;
    checks++;
    if (bus.dbg_ack !== 1'b1 || bus.rom_ce !== 1'b0 || bus.rom_addr !== 32'h0) begin
      errors++;
      $display("FAIL dbg_mis_grant: dack=%b ce=%b addr=%h want 1 0 0", bus.dbg_ack, bus.rom_ce, bus.rom_addr);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_port !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL dbg_mis_rsp: valid=%b port=%b err=%b data=%h want 1 1 1 0",
               bus.rsp_valid, bus.rsp_port, bus.rsp_err, bus.rsp_data);
    end
  endtask

  // Reset between a grant and its response drops the response and the starvation count.
  task automatic test_reset_midflight();
    idle_cycle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      drive(1'b1, 32'h20, 1'b1, 32'h30);
    end
    @(negedge clock);
    drive(1'b1, 32'h20, 1'b1, 32'h30);
    #1;
    checks++;
    if (bus.if_ack !== 1'b1) begin
      errors++;
      $display("FAIL midflight_grant: ack=%b want 1", bus.if_ack);
    end
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midflight_rsp: valid=%b want 0", bus.rsp_valid);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c <= LIMIT; c++) begin
      if (c > 0) @(negedge clock);
      drive(1'b1, 32'h20, 1'b1, 32'h30);
      #1;
      checks++;
      if (bus.dbg_ack !== (c == LIMIT)) begin
        errors++;
        $display("FAIL midflight_cnt_c%0d: dack=%b want %b", c, bus.dbg_ack, (c == LIMIT));
      end
      @(posedge clock);
    end
  endtask

  // Consecutive IF fetches give consecutive responses.
  task automatic test_back_to_back();
    idle_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(1'b1, 32'(4 * i), 1'b0, 32'h0);
      @(posedge clock);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_port !== 1'b0 || bus.rsp_data !== mem[i]) begin
        errors++;
        $display("FAIL b2b_%0d: valid=%b port=%b data=%h want 1 0 %h", i, bus.rsp_valid, bus.rsp_port, bus.rsp_data, mem[i]);
      end
    end
  endtask

  // Random traffic against a model: debug waits for at most LIMIT consecutive IF wins.
  task automatic test_random();
    int          if_wins_over_dbg;
    logic        m_valid, m_port, m_err;
    logic [31:0] m_data;
    logic        ir, dr, e_if, e_dbg, e_ok;
    logic [31:0] ia, da, e_addr;

    @(negedge clock);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    if_wins_over_dbg = 0;
    m_valid = 1'b0; m_port = 1'b0; m_err = 1'b0; m_data = 32'h0;
    ir = 1'b0; dr = 1'b0; ia = 32'h0; da = 32'h0;
    e_if = 1'b0; e_dbg = 1'b0;

    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      // Unacked requests are usually held; occasionally dropped or replaced.
      if (!(ir && !e_if && $urandom_range(0, 9) != 0)) begin
        ir = ($urandom_range(0, 2) != 0);
        ia = $urandom();
        if ($urandom_range(0, 3) != 0) ia[1:0] = 2'b00;
      end
      if (!(dr && !e_dbg && $urandom_range(0, 9) != 0)) begin
        dr = ($urandom_range(0, 2) != 0);
        da = $urandom();
        if ($urandom_range(0, 3) != 0) da[1:0] = 2'b00;
      end
      drive(ir, ia, dr, da);

      e_dbg  = dr && (!ir || if_wins_over_dbg >= LIMIT);
      e_if   = ir && !e_dbg;
      e_addr = e_dbg ? da : ia;
      e_ok   = (e_if || e_dbg) && (e_addr % 4 == 0);
      #1;
      checks++;
      if (bus.if_ack !== e_if || bus.dbg_ack !== e_dbg || bus.if_stall !== (ir && !e_if) ||
          bus.rom_ce !== e_ok || bus.rom_addr !== (e_ok ? e_addr : 32'h0)) begin
        errors++;
        $display("FAIL rand_grant_c%0d: ack=%b dack=%b stall=%b ce=%b addr=%h want %b %b %b %b %h",
                 c, bus.if_ack, bus.dbg_ack, bus.if_stall, bus.rom_ce, bus.rom_addr,
                 e_if, e_dbg, ir && !e_if, e_ok, e_ok ? e_addr : 32'h0);
      end

      if (e_if || e_dbg) begin
        m_valid = 1'b1;
        m_port  = e_dbg;
        m_err   = (e_addr % 4 != 0);
        m_data  = m_err ? 32'h0 : mem[(e_addr / 4) % 256];
      end else begin
        m_valid = 1'b0;
        m_err   = 1'b0;
      end
      if (e_dbg || !dr) if_wins_over_dbg = 0;
      else if (e_if) if_wins_over_dbg = if_wins_over_dbg + 1;

      @(posedge clock);
      #1;
      checks++;
      if (bus.rsp_valid !== m_valid || bus.rsp_port !== m_port || bus.rsp_data !== m_data || bus.rsp_err !== m_err) begin
        errors++;
        $display("FAIL rand_rsp_c%0d: valid=%b port=%b data=%h err=%b want %b %b %h %b",
                 c, bus.rsp_valid, bus.rsp_port, bus.rsp_data, bus.rsp_err, m_valid, m_port, m_data, m_err);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    test_reset();
    test_if_single();
    test_starve();
    test_dbg_misaligned();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
